fir_decim_out: RTL
==================

Name: fir_decim_out

Overview:
- Output stage directly downstream of the 37-tap transposed FIR.
- Consumes the FIR's 20-bit signed result, which arrives one per clock.
- Discards the pipeline-fill warm-up samples, then decimates by DECIM.
- Rounds and saturates each kept sample to 16 bits and buffers it in a small FIFO, drained through a valid/ready stream interface.

Parameters:
- IN_W, 20: input sample width (FIR output width).
- OUT_W, 16: output sample width.
- DECIM, 2: decimation factor, ≥1; DECIM=1 passes every sample.
- WARMUP, 36: number of input samples discarded after reset or clr (FIR taps − 1).
- DEPTH, 8: FIFO depth, power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear: flush FIFO, restart warm-up, clear sticky flags.
- in_valid  in  1  data_in qualifier (tie to 1 behind the free-running FIR).
- data_in  in  IN_W  signed FIR output.
- m_valid  out  1  m_data holds a valid sample.
- m_ready  in  1  sink accepts; transfer occurs when m_valid && m_ready.
- m_data  out  OUT_W  signed rounded/saturated sample (FIFO head, show-ahead).
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- sat_flag  out  1  sticky: at least one sample saturated.
- ovf_flag  out  1  sticky: at least one sample dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n low):
  - state=WARM, warm-up count=0, phase=0, round register invalid, FIFO empty.
  - m_valid=0, m_data=0, fifo_level=0, sat_flag=0, ovf_flag=0.
  - Applies immediately, including mid-stream; all in-flight data is lost.
- FSM with two states, WARM and RUN:
  - WARM: each in_valid cycle increments wcnt. When wcnt reaches WARMUP−1 on an in_valid cycle, go to RUN. None of these WARMUP samples is kept.
  - RUN: phase counter counts in_valid cycles, 0..DECIM−1, and wraps to 0. A sample is kept when in_valid && phase==0, so the first kept sample is input index WARMUP.
  - in_valid=0 freezes wcnt and phase.
- Arithmetic on each kept sample:
  - Sign-extend to IN_W+1 bits.
  - Add 2^(IN_W−OUT_W−1) (= 8), then arithmetic shift right by IN_W−OUT_W (= 4). This is round-half-up.
  - Clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Set sat_flag whenever clamping changes the value.
- Pipeline:
  - Edge t: the kept sample is rounded into the round register.
  - Edge t+1: round register written to the FIFO.
  - m_valid=1 and m_data valid from edge t+1. Latency in_valid→m_valid is 2 clocks with the FIFO empty.
- FIFO:
  - Show-ahead: m_data is always the head entry; m_data holds its last value while empty.
  - Write while full with no read in the same cycle: the new sample is dropped, ovf_flag is set, FIFO contents are unchanged.
  - Write and read in the same cycle while full: both succeed, level unchanged.
  - Read while empty: m_valid=0, so no transfer occurs.
  - Samples leave in FIFO order; level never exceeds DEPTH.
- clr (synchronous, priority over all other activity in that cycle):
  - Next cycle: FIFO empty, round register invalid, state=WARM, wcnt=0, phase=0, sat_flag=0, ovf_flag=0, m_valid=0.
  - The sample presented in the clr cycle is discarded.
- Sticky flags clear only on rst_n or clr.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_TAPS=37, FIR_IN_W=15, FIR_OUT_W=20, DEC_OUT_W=16, DEC_WARMUP=FIR_TAPS−1.
  - The FSM state enum {WARM, RUN}.
- One sub-module, fir_out_fifo:
  - Synchronous, show-ahead, parameterised on width and depth.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, level, clr.
- Counters, FSM and the round/saturate logic stay in the top module.

Test Plan:
1. Reset; in_valid=1 every cycle; data_in=16·k for k=0,1,2,…; m_ready=1; defaults → first m_data is 36, first m_valid 2 cycles after k=36; then 38, 40, … every second cycle; flags stay 0.
2. Rounding, DECIM=1 after warm-up: 100→6, 7→0, 8→1, −8→0, −24→−1, −524288→−32768; sat_flag stays 0.
3. data_in=524287 → m_data=32767 and sat_flag=1. Following data_in=32 → m_data=2 and sat_flag stays 1.
4. RUN with m_ready=0 → fifo_level climbs to 8, then the 9th kept sample is dropped and ovf_flag=1. Raise m_ready → exactly 8 samples drain in input order, then m_valid=0.
5. Full FIFO, m_ready=1 on the same cycle as a kept sample → fifo_level stays 8, nothing dropped, ovf_flag unchanged.
6. clr pulse mid-run with the FIFO half full → next cycle fifo_level=0, m_valid=0, flags 0; the next 36 inputs are discarded. Repeat using an async rst_n pulse mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR filter and its decimating output stage.
package fir_pkg;

   localparam int FIR_TAPS   = 37;
   localparam int FIR_IN_W   = 15;
   localparam int FIR_OUT_W  = 20;
   localparam int DEC_OUT_W  = 16;
   localparam int DEC_WARMUP = FIR_TAPS - 1;

   // Output-stage control: discard pipeline fill, then keep every DECIM-th sample.
   typedef enum logic {
      WARM = 1'b0,
      RUN  = 1'b1
   } dec_state_e;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on rd_data;
// when empty, rd_data keeps the last head value that was shown.
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int W     = DEC_OUT_W,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [W-1:0]                 wr_data,
   input  logic                         rd_en,
   output logic [W-1:0]                 rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int MW = 1 << AW;

   logic [W-1:0]  mem_q [MW];
   logic [W-1:0]  mem_d [MW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [W-1:0]  last_q, last_d;
   logic          do_rd_s;
   logic          do_wr_s;
   logic [W-1:0]  head_s;

   assign empty   = (level_q == LW'(0));
   assign full    = (level_q == LW'(DEPTH));
   assign level   = level_q;
   assign head_s  = mem_q[rd_ptr_q];
   assign rd_data = empty ? last_q : head_s;

   // A write into a full FIFO only succeeds when a read frees a slot in the same cycle.
   assign do_rd_s = rd_en && !empty;
   assign do_wr_s = wr_en && (!full || do_rd_s);

   // Next-state for storage, pointers, occupancy and the held head value.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      last_d   = last_q;
      if (clr) begin
         wr_ptr_d = AW'(0);
         rd_ptr_d = AW'(0);
         level_d  = LW'(0);
         if (!empty) begin
            last_d = head_s;
         end else begin
            last_d = last_q;
         end
      end else begin
         if (do_wr_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = head_s;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         level_d = level_q + LW'(do_wr_s) - LW'(do_rd_s);
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         level_q  <= LW'(0);
         last_q   <= W'(0);
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: drop the warm-up samples, decimate, round half-up,
// saturate to OUT_W bits and buffer the result for a valid/ready sink.
module fir_decim_out
   import fir_pkg::*;
#(
   parameter int IN_W   = FIR_OUT_W,
   parameter int OUT_W  = DEC_OUT_W,
   parameter int DECIM  = 2,
   parameter int WARMUP = DEC_WARMUP,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic [IN_W-1:0]              data_in,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [OUT_W-1:0]             m_data,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic                         sat_flag,
   output logic                         ovf_flag
);

   localparam int SH  = IN_W - OUT_W;
   localparam int SW  = IN_W + 1;
   localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic signed [SW-1:0] RND_ADD = SW'(2 ** (SH - 1));
   localparam logic signed [SW-1:0] MAX_V   = SW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [SW-1:0] MIN_V   = SW'(-(2 ** (OUT_W - 1)));

   dec_state_e     state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [PW-1:0]  phase_q, phase_d;
   logic           keep_s;

   logic signed [SW-1:0] ext_s, sum_s, shf_s;
   logic [OUT_W-1:0]     rnd_s;
   logic                 sat_s;

   logic [OUT_W-1:0] rnd_q, rnd_d;
   logic             rnd_vld_q, rnd_vld_d;
   logic             sat_q, sat_d;
   logic             ovf_q, ovf_d;
   logic             fifo_full_s, fifo_empty_s;
   logic             drop_s;

   // FSM and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WARM;
         wcnt_q  <= WCW'(0);
         phase_q <= PW'(0);
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         phase_q <= phase_d;
      end
   end

   // Next state: count off the warm-up samples, then cycle the decimation phase.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      phase_d = phase_q;
      if (clr) begin
         state_d = WARM;
         wcnt_d  = WCW'(0);
         phase_d = PW'(0);
      end else if (in_valid) begin
         case (state_q)
            WARM: begin
               if (wcnt_q == WCW'(WARMUP - 1)) begin
                  state_d = RUN;
                  wcnt_d  = WCW'(0);
               end else begin
                  wcnt_d = wcnt_q + WCW'(1);
               end
            end
            RUN: begin
               if (phase_q == PW'(DECIM - 1)) begin
                  phase_d = PW'(0);
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            default: begin
               state_d = WARM;
               wcnt_d  = WCW'(0);
               phase_d = PW'(0);
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FSM output: a sample is kept on phase 0 of RUN; a clr cycle keeps nothing.
   always_comb begin
      keep_s = 1'b0;
      case (state_q)
         RUN:     keep_s = in_valid && (phase_q == PW'(0)) && !clr;
         WARM:    keep_s = 1'b0;
         default: keep_s = 1'b0;
      endcase
   end

   // Round half-up by adding half an output LSB before the arithmetic shift, then clamp.
   always_comb begin
      ext_s = {data_in[IN_W-1], data_in};
      sum_s = ext_s + RND_ADD;
      shf_s = sum_s >>> SH;
      if (shf_s > MAX_V) begin
         rnd_s = MAX_V[OUT_W-1:0];
         sat_s = 1'b1;
      end else if (shf_s < MIN_V) begin
         rnd_s = MIN_V[OUT_W-1:0];
         sat_s = 1'b1;
      end else begin
         rnd_s = shf_s[OUT_W-1:0];
         sat_s = 1'b0;
      end
   end

   // A full FIFO drops the round register's sample unless the sink reads this cycle.
   assign drop_s = rnd_vld_q && fifo_full_s && !m_ready;

   // Next state for the round register and the sticky flags.
   always_comb begin
      rnd_d     = rnd_q;
      rnd_vld_d = 1'b0;
      sat_d     = sat_q;
      ovf_d     = ovf_q;
      if (clr) begin
         rnd_vld_d = 1'b0;
         sat_d     = 1'b0;
         ovf_d     = 1'b0;
      end else begin
         if (keep_s) begin
            rnd_d     = rnd_s;
            rnd_vld_d = 1'b1;
            sat_d     = sat_q | sat_s;
         end else begin
            rnd_vld_d = 1'b0;
         end
         if (drop_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
      end
   end

   // Round register and sticky flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_q     <= OUT_W'(0);
         rnd_vld_q <= 1'b0;
         sat_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         rnd_q     <= rnd_d;
         rnd_vld_q <= rnd_vld_d;
         sat_q     <= sat_d;
         ovf_q     <= ovf_d;
      end
   end

   fir_out_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .wr_en   (rnd_vld_q),
      .wr_data (rnd_q),
      .rd_en   (m_ready),
      .rd_data (m_data),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (fifo_level)
   );

   assign m_valid  = !fifo_empty_s;
   assign sat_flag = sat_q;
   assign ovf_flag = ovf_q;

endmodule
